// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute/writeback slice: ALUOp encoding and data word type.
package alu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  alu_op_t;

  localparam alu_op_t ALU_AND = 2'b00;
  localparam alu_op_t ALU_OR  = 2'b01;
  localparam alu_op_t ALU_ADD = 2'b10;
  localparam alu_op_t ALU_SUB = 2'b11;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Bundle of the instruction handshake, alu32 drive/return, writeback and debug signals.
// The stage uses the slave view; whatever feeds it and hosts alu32 uses the master view.
interface alu_exec_stage_if
  import alu_pkg::*;
#(
  parameter int NREG = 8
);
  localparam int AW = $clog2(NREG);

  logic          in_valid;
  logic          in_ready;
  alu_op_t       in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic          in_use_imm;
  word_t         in_imm;
  logic          stall;
  word_t         alu_a;
  word_t         alu_b;
  alu_op_t       alu_op;
  word_t         alu_result;
  logic          alu_carry;
  logic          alu_ovf;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  word_t         wb_data;
  logic          flag_c;
  logic          flag_v;
  logic          flag_z;
  logic [AW-1:0] dbg_addr;
  word_t         dbg_data;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, stall,
    input  alu_result, alu_carry, alu_ovf, dbg_addr,
    output in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data,
    output flag_c, flag_v, flag_z, dbg_data
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, stall,
    output alu_result, alu_carry, alu_ovf, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data,
    input  flag_c, flag_v, flag_z, dbg_data
  );

endinterface

// File: rtl/alu_regfile.sv
// NREG x 32 register file: two operand read ports, a debug read port, one write port.
// Register 0 is never written, so it reads as zero everywhere.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1_addr,
  output word_t         rs1_data,
  input  logic [AW-1:0] rs2_addr,
  output word_t         rs2_data,
  input  logic [AW-1:0] dbg_addr,
  output word_t         dbg_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  word_t         wr_data
);

  word_t regs_q [NREG];
  word_t regs_d [NREG];

  // Next-state of the array: apply the write unless it targets register 0.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Storage with asynchronous clear of every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rs1_data = regs_q[rs1_addr];
  assign rs2_data = regs_q[rs2_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/writeback stage in front of alu32: accepts instructions, resolves operands
// (with forwarding from EX), drives alu32 from the EX register and retires its result.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int NREG = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_exec_stage_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  logic          ex_valid_q, ex_valid_d;
  alu_op_t       ex_op_q, ex_op_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;
  word_t         ex_a_q, ex_a_d;
  word_t         ex_b_q, ex_b_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_rd_q, wb_rd_d;
  word_t         wb_data_q, wb_data_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_v_q, flag_v_d;
  logic          flag_z_q, flag_z_d;

  logic  accept;
  logic  retire;
  word_t rf_rs1;
  word_t rf_rs2;

  // Index 0 is hard zero; the EX result wins over the not-yet-written register file.
  function automatic word_t resolve(input logic [AW-1:0] idx, input logic fwd_valid,
                                    input logic [AW-1:0] fwd_rd, input word_t fwd_val,
                                    input word_t rf_val);
    if (idx == '0) begin
      return '0;
    end else if (fwd_valid && (fwd_rd == idx)) begin
      return fwd_val;
    end else begin
      return rf_val;
    end
  endfunction

  alu_regfile #(.NREG(NREG), .AW(AW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (bus.in_rs1),
    .rs1_data (rf_rs1),
    .rs2_addr (bus.in_rs2),
    .rs2_data (rf_rs2),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data),
    .wr_en    (retire),
    .wr_addr  (ex_rd_q),
    .wr_data  (bus.alu_result)
  );

  // EX register next-state: hold under stall, otherwise load on accept or go empty.
  always_comb begin
    accept     = bus.in_valid & ~bus.stall;
    ex_valid_d = bus.stall ? ex_valid_q : accept;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    if (accept) begin
      ex_op_d = bus.in_op;
      ex_rd_d = bus.in_rd;
      ex_a_d  = resolve(bus.in_rs1, ex_valid_q, ex_rd_q, bus.alu_result, rf_rs1);
      ex_b_d  = bus.in_use_imm ? bus.in_imm
                               : resolve(bus.in_rs2, ex_valid_q, ex_rd_q, bus.alu_result, rf_rs2);
    end
  end

  // Writeback and flag next-state: capture the ALU outcome whenever EX retires.
  always_comb begin
    retire     = ex_valid_q & ~bus.stall;
    wb_valid_d = retire;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    flag_c_d   = flag_c_q;
    flag_v_d   = flag_v_q;
    flag_z_d   = flag_z_q;
    if (retire) begin
      wb_rd_d   = ex_rd_q;
      wb_data_d = bus.alu_result;
      flag_c_d  = bus.alu_carry;
      flag_v_d  = bus.alu_ovf;
      flag_z_d  = (bus.alu_result == '0);
    end
  end

  // Pipeline state; reset discards any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= ALU_AND;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      flag_c_q   <= 1'b0;
      flag_v_q   <= 1'b0;
      flag_z_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      flag_c_q   <= flag_c_d;
      flag_v_q   <= flag_v_d;
      flag_z_q   <= flag_z_d;
    end
  end

  assign bus.in_ready = ~bus.stall;
  assign bus.alu_a    = ex_valid_q ? ex_a_q : '0;
  assign bus.alu_b    = ex_valid_q ? ex_b_q : '0;
  assign bus.alu_op   = ex_valid_q ? ex_op_q : ALU_AND;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.flag_c   = flag_c_q;
  assign bus.flag_v   = flag_v_q;
  assign bus.flag_z   = flag_z_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural stand-in for alu32.
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_exec_stage_if #(.NREG(8)) bus ();

  alu_exec_stage #(.NREG(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for alu32: result, carry (SUB carry = no borrow) and signed overflow.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum       = '0;
    bus.alu_carry = 1'b0;
    bus.alu_ovf   = 1'b0;
    case (bus.alu_op)
      ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      ALU_ADD: begin
        alu_sum        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = alu_sum[31:0];
        bus.alu_carry  = alu_sum[32];
        bus.alu_ovf    = (bus.alu_a[31] == bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
      end
      default: begin
        alu_sum        = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        bus.alu_result = alu_sum[31:0];
        bus.alu_carry  = alu_sum[32];
        bus.alu_ovf    = (bus.alu_a[31] != bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
      end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input alu_op_t op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic use_imm, input word_t imm);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
    step();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.stall      = 1'b0;
    bus.dbg_addr   = '0;
    bus.in_valid   = 1'b1;
    bus.in_op      = ALU_ADD;
    bus.in_rd      = 3'd2;
    bus.in_rs1     = 3'd0;
    bus.in_rs2     = 3'd0;
    bus.in_use_imm = 1'b1;
    bus.in_imm     = 32'h99;
    step();
    step();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_in_ready got %b expected 1", bus.in_ready); end
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wb_valid got %b expected 0", bus.wb_valid); end
    vectors++; if (bus.wb_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_wb_data got %h expected 0", bus.wb_data); end
    vectors++; if (bus.wb_rd !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_wb_rd got %0d expected 0", bus.wb_rd); end
    vectors++; if ({bus.flag_c, bus.flag_v, bus.flag_z} !== 3'b000) begin miscompares++; $display("[TB] FAIL rst_flags got %b expected 000", {bus.flag_c, bus.flag_v, bus.flag_z}); end
    vectors++; if (bus.alu_b !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_alu_b got %h expected 0", bus.alu_b); end
    vectors++; if (bus.alu_op !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_alu_op got %b expected 00", bus.alu_op); end
    bus.stall = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_ready_stall got %b expected 0", bus.in_ready); end
    bus.stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      vectors++; if (bus.dbg_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_dbg r%0d got %h expected 0", i, bus.dbg_data); end
    end
    idle();
    rst_n = 1'b1;
    step();
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_wb_valid got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_imm_add();
    send(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h5);
    idle();
    vectors++; if (bus.alu_a !== 32'h0) begin miscompares++; $display("[TB] FAIL add_alu_a got %h expected 0", bus.alu_a); end
    vectors++; if (bus.alu_b !== 32'h5) begin miscompares++; $display("[TB] FAIL add_alu_b got %h expected 5", bus.alu_b); end
    vectors++; if (bus.alu_op !== ALU_ADD) begin miscompares++; $display("[TB] FAIL add_alu_op got %b expected 10", bus.alu_op); end
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_wb_early got %b expected 0", bus.wb_valid); end
    step();
    vectors++; if (bus.wb_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_wb_valid got %b expected 1", bus.wb_valid); end
    vectors++; if (bus.wb_rd !== 3'd1) begin miscompares++; $display("[TB] FAIL add_wb_rd got %0d expected 1", bus.wb_rd); end
    vectors++; if (bus.wb_data !== 32'h5) begin miscompares++; $display("[TB] FAIL add_wb_data got %h expected 5", bus.wb_data); end
    vectors++; if ({bus.flag_c, bus.flag_v, bus.flag_z} !== 3'b000) begin miscompares++; $display("[TB] FAIL add_flags got %b expected 000", {bus.flag_c, bus.flag_v, bus.flag_z}); end
    bus.dbg_addr = 3'd1;
    #1;
    vectors++; if (bus.dbg_data !== 32'h5) begin miscompares++; $display("[TB] FAIL add_dbg_r1 got %h expected 5", bus.dbg_data); end
    step();
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_wb_pulse got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_back_to_back();
    send(ALU_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 32'hFFFF_FFFB);
    vectors++; if (bus.alu_a !== 32'h5) begin miscompares++; $display("[TB] FAIL b2b_alu_a got %h expected 5", bus.alu_a); end
    send(ALU_SUB, 3'd3, 3'd2, 3'd2, 1'b0, 32'h0);
    idle();
    vectors++; if (bus.wb_data !== 32'h0) begin miscompares++; $display("[TB] FAIL b2b_first_data got %h expected 0", bus.wb_data); end
    vectors++; if ({bus.flag_c, bus.flag_v, bus.flag_z} !== 3'b101) begin miscompares++; $display("[TB] FAIL b2b_first_flags got %b expected 101", {bus.flag_c, bus.flag_v, bus.flag_z}); end
    vectors++; if (bus.alu_op !== ALU_SUB) begin miscompares++; $display("[TB] FAIL b2b_alu_op got %b expected 11", bus.alu_op); end
    step();
    vectors++; if (bus.wb_rd !== 3'd3) begin miscompares++; $display("[TB] FAIL b2b_second_rd got %0d expected 3", bus.wb_rd); end
    vectors++; if (bus.wb_data !== 32'h0) begin miscompares++; $display("[TB] FAIL b2b_second_data got %h expected 0", bus.wb_data); end
    vectors++; if ({bus.flag_c, bus.flag_v, bus.flag_z} !== 3'b101) begin miscompares++; $display("[TB] FAIL b2b_second_flags got %b expected 101", {bus.flag_c, bus.flag_v, bus.flag_z}); end
  endtask

  task automatic test_overflow();
    send(ALU_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 32'h7FFF_FFFF);
    send(ALU_ADD, 3'd5, 3'd4, 3'd0, 1'b1, 32'h1);
    vectors++; if (bus.wb_data !== 32'h7FFF_FFFF) begin miscompares++; $display("[TB] FAIL ovf_r4_data got %h expected 7fffffff", bus.wb_data); end
    vectors++; if (bus.alu_a !== 32'h7FFF_FFFF) begin miscompares++; $display("[TB] FAIL ovf_fwd_a got %h expected 7fffffff", bus.alu_a); end
    send(ALU_AND, 3'd6, 3'd5, 3'd5, 1'b0, 32'h0);
    idle();
    vectors++; if (bus.wb_data !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL ovf_r5_data got %h expected 80000000", bus.wb_data); end
    vectors++; if ({bus.flag_c, bus.flag_v, bus.flag_z} !== 3'b010) begin miscompares++; $display("[TB] FAIL ovf_r5_flags got %b expected 010", {bus.flag_c, bus.flag_v, bus.flag_z}); end
    vectors++; if (bus.alu_b !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL ovf_fwd_b got %h expected 80000000", bus.alu_b); end
    step();
    vectors++; if (bus.wb_rd !== 3'd6) begin miscompares++; $display("[TB] FAIL and_wb_rd got %0d expected 6", bus.wb_rd); end
    vectors++; if (bus.wb_data !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL and_wb_data got %h expected 80000000", bus.wb_data); end
    vectors++; if ({bus.flag_c, bus.flag_v, bus.flag_z} !== 3'b000) begin miscompares++; $display("[TB] FAIL and_flags got %b expected 000", {bus.flag_c, bus.flag_v, bus.flag_z}); end
    bus.dbg_addr = 3'd4;
    #1;
    vectors++; if (bus.dbg_data !== 32'h7FFF_FFFF) begin miscompares++; $display("[TB] FAIL ovf_dbg_r4 got %h expected 7fffffff", bus.dbg_data); end
    step();
  endtask

  task automatic test_distance_two();
    send(ALU_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 32'h10);
    send(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h3);
    send(ALU_ADD, 3'd2, 3'd7, 3'd7, 1'b0, 32'h0);
    idle();
    vectors++; if (bus.alu_a !== 32'h10) begin miscompares++; $display("[TB] FAIL dist2_alu_a got %h expected 10", bus.alu_a); end
    vectors++; if (bus.alu_b !== 32'h10) begin miscompares++; $display("[TB] FAIL dist2_alu_b got %h expected 10", bus.alu_b); end
    step();
    vectors++; if (bus.wb_data !== 32'h20) begin miscompares++; $display("[TB] FAIL dist2_wb_data got %h expected 20", bus.wb_data); end
    step();
  endtask

  task automatic test_stall();
    send(ALU_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'h22);
    send(ALU_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 32'h33);
    bus.stall  = 1'b1;
    bus.in_rd  = 3'd4;
    bus.in_imm = 32'h44;
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_in_ready got %b expected 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_wb_valid cycle %0d got %b expected 0", i, bus.wb_valid); end
      vectors++; if (bus.alu_b !== 32'h33) begin miscompares++; $display("[TB] FAIL stall_alu_b cycle %0d got %h expected 33", i, bus.alu_b); end
    end
    bus.stall = 1'b0;
    step();
    idle();
    vectors++; if (bus.wb_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL release_wb_valid got %b expected 1", bus.wb_valid); end
    vectors++; if (bus.wb_rd !== 3'd3) begin miscompares++; $display("[TB] FAIL release_wb_rd got %0d expected 3", bus.wb_rd); end
    vectors++; if (bus.wb_data !== 32'h33) begin miscompares++; $display("[TB] FAIL release_wb_data got %h expected 33", bus.wb_data); end
    vectors++; if (bus.alu_b !== 32'h44) begin miscompares++; $display("[TB] FAIL release_accept_b got %h expected 44", bus.alu_b); end
    step();
    vectors++; if (bus.wb_rd !== 3'd4) begin miscompares++; $display("[TB] FAIL next_wb_rd got %0d expected 4", bus.wb_rd); end
    vectors++; if (bus.wb_data !== 32'h44) begin miscompares++; $display("[TB] FAIL next_wb_data got %h expected 44", bus.wb_data); end
    step();
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_drain_wb got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_r0_target();
    send(ALU_OR, 3'd0, 3'd0, 3'd0, 1'b1, 32'hA5);
    vectors++; if (bus.alu_op !== ALU_OR) begin miscompares++; $display("[TB] FAIL r0_alu_op got %b expected 01", bus.alu_op); end
    send(ALU_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 32'h1);
    idle();
    vectors++; if (bus.wb_rd !== 3'd0) begin miscompares++; $display("[TB] FAIL r0_wb_rd got %0d expected 0", bus.wb_rd); end
    vectors++; if (bus.wb_data !== 32'hA5) begin miscompares++; $display("[TB] FAIL r0_wb_data got %h expected a5", bus.wb_data); end
    vectors++; if (bus.alu_a !== 32'h0) begin miscompares++; $display("[TB] FAIL r0_no_fwd got %h expected 0", bus.alu_a); end
    bus.dbg_addr = 3'd0;
    #1;
    vectors++; if (bus.dbg_data !== 32'h0) begin miscompares++; $display("[TB] FAIL r0_dbg got %h expected 0", bus.dbg_data); end
    step();
    vectors++; if (bus.wb_data !== 32'h1) begin miscompares++; $display("[TB] FAIL r0_follow_data got %h expected 1", bus.wb_data); end
  endtask

  task automatic test_async_reset();
    send(ALU_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 32'h0);
    send(ALU_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 32'h1234);
    idle();
    vectors++; if ({bus.flag_c, bus.flag_v, bus.flag_z} !== 3'b001) begin miscompares++; $display("[TB] FAIL pre_rst_flags got %b expected 001", {bus.flag_c, bus.flag_v, bus.flag_z}); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.alu_b !== 32'h0) begin miscompares++; $display("[TB] FAIL arst_alu_b got %h expected 0", bus.alu_b); end
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_wb_valid got %b expected 0", bus.wb_valid); end
    vectors++; if (bus.wb_rd !== 3'd0) begin miscompares++; $display("[TB] FAIL arst_wb_rd got %0d expected 0", bus.wb_rd); end
    vectors++; if (bus.flag_z !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_flag_z got %b expected 0", bus.flag_z); end
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      vectors++; if (bus.dbg_data !== 32'h0) begin miscompares++; $display("[TB] FAIL arst_dbg r%0d got %h expected 0", i, bus.dbg_data); end
    end
    step();
    rst_n = 1'b1;
    step();
    bus.dbg_addr = 3'd6;
    #1;
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_no_retire got %b expected 0", bus.wb_valid); end
    vectors++; if (bus.dbg_data !== 32'h0) begin miscompares++; $display("[TB] FAIL arst_no_write_r6 got %h expected 0", bus.dbg_data); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_imm_add();
    test_back_to_back();
    test_overflow();
    test_distance_two();
    test_stall();
    test_r0_target();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Single-issue execute/writeback stage that sits directly upstream of `alu32`. It accepts register-operand instructions over a valid/ready handshake and reads operands from an internal register file, forwarding in-flight results. It drives `alu32`'s A/B/ALUOp inputs from its EX register, then writes the ALU result back into the register file and latches the carry, overflow and zero flags.

## Interface
Parameters:
- `NREG`, 8, number of 32-bit registers; power of two, ≥ 2
- `AW`, $clog2(NREG), register address width; derived, not overridden

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  instruction present
- `in_ready`  out  1  stage can accept; equals `~stall`
- `in_op`  in  2  ALUOp encoding: 00 AND, 01 OR, 10 ADD, 11 SUB
- `in_rd`, `in_rs1`, `in_rs2`  in  AW each  destination and source register indices
- `in_use_imm`  in  1  B operand is `in_imm` instead of `rs2`
- `in_imm`  in  32  immediate
- `stall`  in  1  downstream hold; freezes EX and blocks acceptance
- `alu_a`, `alu_b`  out  32 each  to `alu32` A/B
- `alu_op`  out  2  to `alu32` ALUOp
- `alu_result`  in  32  from `alu32` Result
- `alu_carry`, `alu_ovf`  in  1 each  from `alu32` CarryOut/Overflow
- `wb_valid`  out  1  one-cycle pulse per retired instruction
- `wb_rd`  out  AW  retired destination index
- `wb_data`  out  32  retired result
- `flag_c`, `flag_v`, `flag_z`  out  1 each  sticky-until-next-retire status flags
- `dbg_addr`  in  AW  debug read address
- `dbg_data`  out  32  combinational register-file read of `dbg_addr`

## Operation
- Accept: `in_valid & in_ready` at a rising edge loads the EX register with op, rd and resolved operands.
  - If there is no accept, EX valid clears, unless `stall` is high.
- Operand resolve, per source, combinational in the accept cycle:
  - Index 0 always yields 0.
  - Otherwise, if EX is valid and the EX rd equals the source index, the operand is `alu_result` (EX forward).
  - Otherwise the operand is the register-file entry.
  - If `in_use_imm` is set, B is `in_imm` and `rs2` is ignored.
- `alu_a`, `alu_b` and `alu_op` are driven straight from the EX register. They are 0/0/00 when EX is invalid.
- Retire: at an edge where EX is valid and `stall` is low, the stage does all of the following in one step:
  - Writes `alu_result` to `regs[rd]`.
  - Registers `wb_valid`=1, `wb_rd` and `wb_data`.
  - Updates `flag_c` = `alu_carry`, `flag_v` = `alu_ovf`, and `flag_z` = (`alu_result` == 0).
- Otherwise `wb_valid` = 0 and the flags hold.
- Writes to register 0 are discarded. They still pulse `wb_valid`, update the flags, and show the true result on `wb_data`.
- Arithmetic is 32-bit modulo. Flag semantics are exactly those of `alu32`: C and V are 0 for AND/OR.
- `dbg_data` reflects the register file only; there is no forwarding on the debug port.

## Timing
- Reset (async assert, sync-release usage):
  - All registers, EX valid, `wb_valid`, `wb_rd`, `wb_data` and all flags go to 0.
  - `in_ready` follows `~stall` even during reset; acceptance is ignored while `rst_n` = 0.
- Latency and throughput:
  - An instruction accepted at edge k is in EX during cycle k→k+1 and retires at edge k+1, provided `stall` is low.
  - `wb_valid` is high in cycle k+1→k+2.
  - Throughput is one instruction per cycle. No data-hazard stalls exist.
- Back-to-back dependency: an instruction accepted at edge k+1 reading the rd of the one accepted at edge k gets the EX forward. At distance 2 it reads the already-written register file.
- `stall` high:
  - EX contents and ALU drive hold, with no retire and no accept.
  - `wb_valid` drops after the next edge.
  - On release, the held instruction retires exactly once.
- Reset mid-operation discards the EX contents with no write.
- Simultaneous retire of rd=X and accept reading X: the accept uses the EX forward, so the value is identical to the value being written.

## Structure
- Shared package `alu_pkg`:
  - ALUOp encoding constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`.
  - Typedef for the 32-bit data word.
- One natural sub-module: `alu_regfile`, an NREG×32 register file with async reset.
  - Ports: two combinational read ports, one debug read port, one synchronous write port, and the r0-zero rule.
- `alu32` is instantiated by the parent integration, not inside this block.

## Test plan
- Reset, then ADD r1 = r0 + imm 5 (use_imm) → `wb_valid` one cycle later, `wb_data`=5, `regs[1]`=5, C=V=Z=0.
- Back-to-back: ADD r2 = r1 + imm 0xFFFF_FFFB (r1=5), then SUB r3 = r2 − r2.
  - First: `wb_data`=0, C=1, Z=1.
  - Second: forwarded r2=0, so `wb_data`=0, C=1 (no borrow), Z=1.
- Overflow: r4 = 0x7FFF_FFFF via imm, then ADD r5 = r4 + imm 1 → `wb_data`=0x8000_0000, V=1, C=0. Then AND r6 = r5 & r5 → C=V=0, Z=0.
- Stall: raise `stall` for 3 cycles with an instruction in EX → `in_ready`=0, no `wb_valid` during the stall, exactly one `wb_valid` after release, and the next `in_valid` is accepted only after release.
- r0 target: OR r0 = r0 | imm 0xA5 → `wb_data`=0xA5, `dbg_addr`=0 gives 0. A following read of r0 yields 0.
- Async reset asserted mid-stream with EX valid → all outputs 0 immediately, no write to that instruction's rd, and `dbg_data` reads 0 for every index.
